// File: rtl/inv_add_round_key_stage.sv
// Inverse-cipher AddRoundKey stage: stores NUM_ROUNDS+1 round keys and XORs each state beat with the key for the current round, counting down.
// Latency: 1 cycle from input accept to out_* (single registered output stage).
// Backpressure: in_ready drops while the output register is full and out_ready is low; there is no skid, and full throughput holds when out_ready is high.
module inv_add_round_key_stage #(
  parameter int NUM_ROUNDS = 10,
  parameter int ROUND_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_clear,
  input  logic               key_wr_en,
  input  logic [127:0]       key_wr_data,
  output logic               keys_ready,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data,
  output logic [ROUND_W-1:0] out_round,
  output logic               out_mix_en,
  output logic               out_last
);

  localparam logic [ROUND_W-1:0] LAST_IDX = ROUND_W'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_IDLE = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t             state;
  logic [ROUND_W-1:0] wr_ptr;
  logic [ROUND_W-1:0] round_cnt;
  logic [127:0]       key_mem [0:NUM_ROUNDS];
  logic [127:0]       round_key;
  logic               accept;
  logic               key_we;

  // Single-entry output register: accept whenever it is empty or being drained.
  assign in_ready  = (state != S_LOAD) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready && !key_clear;
  assign key_we    = key_wr_en && (state == S_LOAD) && !key_clear;
  // In S_IDLE the counter always sits at NUM_ROUNDS, so the counter is the round in both states.
  assign round_key = key_mem[round_cnt];

  // Key storage is deliberately left unreset; keys_ready gates every use of it.
  always_ff @(posedge clk) begin
    if (key_we) begin
      key_mem[wr_ptr] <= key_wr_data;
    end
  end

  // Control FSM, round counter and the registered output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_LOAD;
      wr_ptr     <= '0;
      round_cnt  <= LAST_IDX;
      keys_ready <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_round  <= '0;
      out_mix_en <= 1'b0;
      out_last   <= 1'b0;
    end else if (key_clear) begin
      // Abandon any partial block and wait for a fresh key schedule.
      state      <= S_LOAD;
      wr_ptr     <= '0;
      round_cnt  <= LAST_IDX;
      keys_ready <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (key_wr_en) begin
            wr_ptr <= wr_ptr + ROUND_W'(1);
            if (wr_ptr == LAST_IDX) begin
              state      <= S_IDLE;
              keys_ready <= 1'b1;
            end
          end
        end
        S_IDLE: begin
          if (accept) begin
            round_cnt <= LAST_IDX - ROUND_W'(1);
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (round_cnt == '0) begin
              round_cnt <= LAST_IDX;
              state     <= S_IDLE;
            end else begin
              round_cnt <= round_cnt - ROUND_W'(1);
            end
          end
        end
        default: state <= S_LOAD;
      endcase

      // A new beat overwrites the one being drained in the same cycle.
      if (accept) begin
        out_valid  <= 1'b1;
        out_data   <= in_data ^ round_key;
        out_round  <= round_cnt;
        out_mix_en <= (round_cnt != '0) && (round_cnt != LAST_IDX);
        out_last   <= (round_cnt == '0);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inv_add_round_key_stage.sv
module tb_inv_add_round_key_stage;

  localparam int NR = 10;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_clear = 1'b0;
  logic          key_wr_en = 1'b0;
  logic [127:0]  key_wr_data = '0;
  logic          keys_ready;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [127:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [127:0]  out_data;
  logic [RW-1:0] out_round;
  logic          out_mix_en;
  logic          out_last;

  int checks = 0;
  int failures = 0;

  // Reference model: list of loaded keys, beat position in block, output beat.
  logic [127:0] m_keys [0:NR];
  int           nkeys = 0;
  int           beat = 0;
  bit           mvalid = 0;
  logic [127:0] mdata = '0;
  int           mround = 0;

  inv_add_round_key_stage #(.NUM_ROUNDS(NR), .ROUND_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .key_clear(key_clear), .key_wr_en(key_wr_en),
    .key_wr_data(key_wr_data), .keys_ready(keys_ready), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_round(out_round),
    .out_mix_en(out_mix_en), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_in_ready();
    return (nkeys == NR + 1) && (!mvalid || out_ready);
  endfunction

  task automatic model_reset();
    nkeys = 0; beat = 0; mvalid = 0; mdata = '0; mround = 0;
  endtask

  task automatic check_all();
    chk("keys_ready", keys_ready, nkeys == NR + 1);
    chk("in_ready", in_ready, m_in_ready());
    chk("out_valid", out_valid, mvalid);
    if (mvalid) begin
      chk("out_data", out_data, mdata);
      chk("out_round", out_round, mround);
      chk("out_mix_en", out_mix_en, (mround > 0) && (mround < NR));
      chk("out_last", out_last, mround == 0);
    end
  endtask

  task automatic model_edge();
    bit acc;
    if (key_clear) begin
      nkeys = 0; beat = 0; mvalid = 0;
    end else begin
      acc = in_valid && m_in_ready();
      if (key_wr_en && nkeys <= NR) begin
        m_keys[nkeys] = key_wr_data;
        nkeys++;
      end
      if (acc) begin
        mround = NR - beat;
        mdata  = in_data ^ m_keys[mround];
        mvalid = 1;
        beat   = (beat + 1) % (NR + 1);
      end else if (out_ready) begin
        mvalid = 0;
      end
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic load_keys(input bit rnd);
    for (int i = 0; i <= NR; i++) begin
      key_wr_en   = 1'b1;
      key_wr_data = rnd ? rand128() : {16{i[7:0]}};
      tick();
    end
    key_wr_en = 1'b0;
  endtask

  task automatic random_phase(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      key_wr_en   = $urandom_range(0, 1);
      key_wr_data = rand128();
      in_data     = rand128();
      tick();
    end
    key_wr_en = 1'b0;
  endtask

  initial begin
    int  stall;
    bit  found;

    // Reset values
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_keys_ready", keys_ready, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_round", out_round, 0);
    chk("rst_mix_en", out_mix_en, 0);
    chk("rst_last", out_last, 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed key load with a gap after 5 writes; input held valid throughout
    in_valid  = 1'b1;
    in_data   = '0;
    out_ready = 1'b1;
    for (int i = 0; i <= NR; i++) begin
      if (i == 5) begin
        key_wr_en = 1'b0;
        tick();
        tick();
      end
      key_wr_en   = 1'b1;
      key_wr_data = {16{i[7:0]}};
      tick();
    end
    key_wr_en = 1'b0;
    chk("keys_ready_rise", keys_ready, 1);

    // Block of zero states: output is the key sequence 10..0
    for (int k = 0; k <= NR; k++) begin
      tick();
      if (k == 0) chk("first_beat_data", out_data, {16{8'h0A}});
      if (k == 1) chk("second_beat_mix", out_mix_en, 1);
    end
    chk("last_beat_data", out_data, '0);
    chk("last_beat_flag", out_last, 1);

    // Backpressure at round 7
    stall = 0;
    for (int k = 0; k < 40; k++) begin
      out_ready = !(mvalid && mround == 7 && stall < 3);
      if (!out_ready) stall++;
      in_data = rand128();
      tick();
      if (k > 3 && beat == 0) break;
    end
    out_ready = 1'b1;
    chk("stall_cycles", stall, 3);
    chk("bp_block_done", beat, 0);

    // Two blocks back-to-back of all-ones states
    in_data = '1;
    for (int k = 0; k < 2 * (NR + 1); k++) begin
      tick();
      if (k == NR) chk("blk1_last", out_last, 1);
      if (k == NR + 1) begin
        chk("blk2_first_data", out_data, {16{8'hF5}});
        chk("blk2_first_round", out_round, NR);
      end
    end

    // key_clear while round 4 sits in the output register
    found = 0;
    for (int k = 0; k < 20; k++) begin
      in_data = rand128();
      tick();
      if (mvalid && mround == 4) begin
        found = 1;
        break;
      end
    end
    chk("reach_round4", found, 1);
    key_clear = 1'b1;
    key_wr_en = 1'b1;
    tick();
    key_clear = 1'b0;
    key_wr_en = 1'b0;
    chk("clr_out_valid", out_valid, 0);
    chk("clr_keys_ready", keys_ready, 0);
    chk("clr_in_ready", in_ready, 0);
    tick();
    in_valid = 1'b0;
    load_keys(1);
    in_valid = 1'b1;
    in_data  = rand128();
    tick();
    chk("after_clear_round", out_round, NR);
    random_phase(60);

    // Asynchronous reset mid-block
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = rand128();
      tick();
    end
    rst_n = 1'b0;
    #2;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_keys_ready", keys_ready, 0);
    chk("arst_in_ready", in_ready, 0);
    model_reset();
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    load_keys(1);
    in_valid = 1'b1;
    in_data  = rand128();
    tick();
    chk("after_arst_round", out_round, NR);
    random_phase(150);
    in_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
